branch_predictor: RTL and testbench

Dynamic branch direction predictor for the MIPS pipeline, paired with the branch resolution logic. Queried in ID with the branch PC to supply an early taken/not-taken guess. Trained in EX with the resolved outcome (`needbranch`) and the index captured at query time. Raises `mispredict` so the hazard unit can flush the wrong-path instructions.

---
 rtl/branch_predictor_pkg.sv | 11 +
 rtl/branch_predictor_sat_ctr.sv | 14 +
 rtl/branch_predictor.sv | 49 ++++
 tb/tb_branch_predictor.sv | 171 +++++++++++++++++
 4 files changed

// File: rtl/branch_predictor_pkg.sv
// bp_pkg: shared counter encodings, reset value and index-width helper for the branch predictor
package bp_pkg;
  localparam logic [1:0] BP_SNT = 2'b00;
  localparam logic [1:0] BP_WNT = 2'b01;
  localparam logic [1:0] BP_WT = 2'b10;
  localparam logic [1:0] BP_ST = 2'b11;
  localparam logic [1:0] BP_CTR_RST = BP_WNT;
  function automatic int bp_idx_w(input int depth);
    return $clog2(depth);
  endfunction
endpackage

// File: rtl/branch_predictor_sat_ctr.sv
// bp_sat_ctr: next state of a 2-bit saturating direction counter
module bp_sat_ctr
  import bp_pkg::*;
(
  input  logic [1:0] ctr_i,
  input  logic       taken_i,
  output logic [1:0] ctr_o
);
  // step toward the resolved direction, holding at either end
  always_comb begin
    ctr_o = taken_i ? ((ctr_i == BP_ST) ? BP_ST : ctr_i + 2'd1)
                    : ((ctr_i == BP_SNT) ? BP_SNT : ctr_i - 2'd1);
  end
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit counter PHT direction predictor; define BP_GSHARE_EN to hash a global history into the index
module branch_predictor
  import bp_pkg::*;
#(
  parameter int PHT_DEPTH = 64,
  parameter int GHR_BITS = 6,
  localparam int IDX = bp_idx_w(PHT_DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [31:0]    q_pc,
  input  logic           q_is_branch,
  output logic           q_taken,
  output logic [IDX-1:0] q_index,
  input  logic           u_valid,
  input  logic [IDX-1:0] u_index,
  input  logic           u_pred_taken,
  input  logic           u_taken,
  output logic           mispredict
);
  logic [1:0] pht_q [PHT_DEPTH];
  logic [1:0] ctr_d;
  logic       unused_pc;
  assign unused_pc = ^{q_pc[31:IDX+2], q_pc[1:0]};
`ifdef BP_GSHARE_EN
  logic [GHR_BITS-1:0] ghr_q;
  // history advances only on resolved branches, alongside the table write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ghr_q <= '0;
    else if (u_valid) ghr_q <= (ghr_q << 1) | GHR_BITS'(u_taken);
  end
  assign q_index = q_pc[IDX+1:2] ^ IDX'(ghr_q);
`else
  assign q_index = q_pc[IDX+1:2];
`endif
  // prediction reads the registered table, so a same-cycle update is not seen
  assign q_taken = q_is_branch & pht_q[q_index][1];
  assign mispredict = u_valid & (u_taken != u_pred_taken);
  bp_sat_ctr u_ctr (
    .ctr_i  (pht_q[u_index]),
    .taken_i(u_taken),
    .ctr_o  (ctr_d)
  );
  // flop-array PHT so reset can clear every entry at once
  always_ff @(posedge clk or posedge rst) begin
    if (rst) for (int i = 0; i < PHT_DEPTH; i++) pht_q[i] <= BP_CTR_RST;
    else if (u_valid) pht_q[u_index] <= ctr_d;
  end
endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: directed and random checks of branch_predictor against an array-based model
module tb_branch_predictor;
  localparam int D = 64;
  localparam int IW = 6;
  localparam int GB = 6;
  logic clk = 1'b0;
  logic rst;
  logic [31:0] q_pc;
  logic q_is_branch;
  logic q_taken;
  logic [IW-1:0] q_index;
  logic u_valid;
  logic [IW-1:0] u_index;
  logic u_pred_taken;
  logic u_taken;
  logic mispredict;
  int checks = 0;
  int errors = 0;
  int pht [D];
  int ghr = 0;

  branch_predictor #(.PHT_DEPTH(D), .GHR_BITS(GB)) dut (
    .clk(clk), .rst(rst), .q_pc(q_pc), .q_is_branch(q_is_branch), .q_taken(q_taken),
    .q_index(q_index), .u_valid(u_valid), .u_index(u_index), .u_pred_taken(u_pred_taken),
    .u_taken(u_taken), .mispredict(mispredict)
  );

  always #5 clk = ~clk;

  function automatic int midx(input logic [31:0] pc);
    int i;
    i = int'((pc >> 2) % D);
`ifdef BP_GSHARE_EN
    i = i ^ ghr;
`endif
    return i;
  endfunction

  function automatic logic [31:0] pc_for(input int idx);
    int h;
    h = idx;
`ifdef BP_GSHARE_EN
    h = idx ^ ghr;
`endif
    return 32'h0040_0000 | (32'(h) << 2);
  endfunction

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < D; i++) pht[i] = 1;
    ghr = 0;
  endtask

  task automatic query(input string tag, input logic [31:0] pc, input logic br);
    q_pc = pc;
    q_is_branch = br;
    #1;
    chk({tag, "_idx"}, int'(q_index), midx(pc));
    chk({tag, "_tk"}, int'(q_taken), (br && pht[midx(pc)] >= 2) ? 1 : 0);
  endtask

  task automatic upd(input logic v, input int idx, input logic pred, input logic tk);
    u_valid = v;
    u_index = IW'(idx);
    u_pred_taken = pred;
    u_taken = tk;
    #1;
    chk("mispredict", int'(mispredict), (v && (tk != pred)) ? 1 : 0);
  endtask

  task automatic tick();
    @(posedge clk);
    if (u_valid && !rst) begin
      if (u_taken) pht[u_index] = (pht[u_index] == 3) ? 3 : pht[u_index] + 1;
      else pht[u_index] = (pht[u_index] == 0) ? 0 : pht[u_index] - 1;
      ghr = ((ghr << 1) | int'(u_taken)) & ((1 << GB) - 1);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    q_pc = '0;
    q_is_branch = 1'b0;
    u_valid = 1'b0;
    u_index = '0;
    u_pred_taken = 1'b0;
    u_taken = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    query("reset_q", 32'h0040_0010, 1'b1);
`ifndef BP_GSHARE_EN
    chk("reset_idx4", int'(q_index), 4);
`endif
    upd(1'b0, 0, 1'b0, 1'b1);
    upd(1'b1, 4, 1'b0, 1'b1);
    tick();
    upd(1'b1, 4, 1'b0, 1'b1);
    tick();
    upd(1'b0, 0, 1'b0, 1'b0);
    query("trained_t", pc_for(4), 1'b1);
    upd(1'b1, 4, 1'b1, 1'b1);
    tick();
    for (int n = 0; n < 4; n++) begin
      upd(1'b1, 4, 1'b1, 1'b0);
      tick();
      upd(1'b0, 0, 1'b0, 1'b0);
      query("nt_walk", pc_for(4), 1'b1);
    end
    upd(1'b1, 4, 1'b0, 1'b1);
    tick();
    query("from_snt", pc_for(4), 1'b1);
    upd(1'b1, 4, 1'b0, 1'b1);
    query("same_cycle", pc_for(4), 1'b1);
    tick();
    upd(1'b0, 0, 1'b0, 1'b0);
    query("after_upd", pc_for(4), 1'b1);
    query("not_branch", pc_for(4), 1'b0);
    upd(1'b1, 7, 1'b0, 1'b1);
    tick();
    upd(1'b1, 7, 1'b0, 1'b1);
    tick();
    upd(1'b0, 0, 1'b0, 1'b0);
    query("pre_rst7", pc_for(7), 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    upd(1'b1, 9, 1'b0, 1'b1);
    query("in_rst7", pc_for(7), 1'b1);
    query("in_rst4", pc_for(4), 1'b1);
    tick();
    rst = 1'b0;
    upd(1'b0, 0, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) query("post_rst", pc_for(i), 1'b1);
    upd(1'b1, 9, 1'b0, 1'b1);
    tick();
    upd(1'b0, 0, 1'b0, 1'b0);
    query("rst_upd_drop", pc_for(9), 1'b1);
`ifdef BP_GSHARE_EN
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    @(negedge clk);
    upd(1'b1, 2, 1'b0, 1'b1);
    tick();
    upd(1'b1, 2, 1'b0, 1'b0);
    tick();
    upd(1'b1, 2, 1'b0, 1'b1);
    tick();
    upd(1'b0, 0, 1'b0, 1'b0);
    query("ghr_q", 32'h0040_0010, 1'b1);
    chk("ghr_idx1", int'(q_index), 1);
`endif
    for (int n = 0; n < 400; n++) begin
      upd(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom));
      query("rand", {$urandom} & 32'h0000_00ff, 1'($urandom_range(0, 4) != 0));
      tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
